// File: rtl/tc_line_mem_loader.sv
// Writer for the timingCore tick/pixel line memories: initial fill of all frames, then one refill per consumed bank.
// Optional stall counter enabled by defining TC_LOADER_STALL_CNT_EN.
module tc_line_mem_loader #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 17,
  parameter int SEL_W  = 3
) (
  input  logic              clk_r,
  input  logic              nrst_r,
  input  logic              start_i,
  input  logic              stop_i,
  input  logic [9:0]        points_per_line_i,
  input  logic [2:0]        number_of_frames_i,
  input  logic [DATA_W-1:0] s_data_i,
  input  logic              s_valid_i,
  output logic              s_ready_o,
  input  logic              update_mem_i,
  output logic [ADDR_W-1:0] waddr_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic              we_o,
  output logic [SEL_W-1:0]  memory_selector_o,
  output logic              mem_updated_o,
  output logic              init_done_o,
  output logic              busy_o,
  output logic              overrun_o,
  output logic [15:0]       stall_cnt_o
);

  typedef enum logic [1:0] {IDLE, INIT_FILL, ARMED, REFILL} state_t;

  state_t            state_reg, state_next;
  logic [9:0]        ppl_reg, ppl_next;
  logic [9:0]        word_reg, word_next;
  logic [SEL_W-1:0]  nof_reg, nof_next;
  logic [SEL_W-1:0]  frame_reg, frame_next;
  logic [SEL_W-1:0]  rptr_reg, rptr_next;
  logic [ADDR_W-1:0] waddr_reg, waddr_next;
  logic [DATA_W-1:0] wdata_reg, wdata_next;
  logic              we_reg, we_next;
  logic [SEL_W-1:0]  sel_reg, sel_next;
  logic              mu_reg, mu_next;
  logic              init_done_reg, init_done_next;
  logic              overrun_reg, overrun_next;

  // [0],[1] capture update_mem_i; [2] holds the previous captured level
  logic [2:0]        upd_sh_reg;
  logic              upd_edge;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_upd_sh
      always_ff @(posedge clk_r or negedge nrst_r) begin
        if (!nrst_r) begin
          upd_sh_reg[gi] <= 1'b0;
        end else if (gi == 0) begin
          upd_sh_reg[gi] <= update_mem_i;
        end else begin
          upd_sh_reg[gi] <= upd_sh_reg[(gi > 0) ? gi - 1 : 0];
        end
      end
    end
  endgenerate

  assign upd_edge = upd_sh_reg[1] ^ upd_sh_reg[2];

  logic             filling;
  logic             accept;
  logic             last_word;
  logic             start_ok;
  logic [2:0]       nof_clamped;
  logic [SEL_W-1:0] rptr_adv;

  assign filling   = (state_reg == INIT_FILL) || (state_reg == REFILL);
  // stop_i drops ready so a beat offered during abort is never silently lost
  assign s_ready_o = filling && (word_reg < ppl_reg) && !stop_i;
  assign accept    = s_valid_i && s_ready_o;
  assign last_word = (word_reg == ppl_reg - 10'd1);
  assign start_ok  = (state_reg == IDLE) && start_i && !stop_i;
  assign rptr_adv  = (rptr_reg == nof_reg - SEL_W'(1)) ? '0 : rptr_reg + SEL_W'(1);

  always_comb begin
    nof_clamped = number_of_frames_i;
    if (number_of_frames_i == 3'd0) begin
      nof_clamped = 3'd1;
    end else if (number_of_frames_i > 3'd5) begin
      nof_clamped = 3'd5;
    end
  end

  always_comb begin
    state_next     = state_reg;
    ppl_next       = ppl_reg;
    word_next      = word_reg;
    nof_next       = nof_reg;
    frame_next     = frame_reg;
    rptr_next      = rptr_reg;
    waddr_next     = waddr_reg;
    wdata_next     = wdata_reg;
    we_next        = 1'b0;
    sel_next       = sel_reg;
    mu_next        = mu_reg;
    init_done_next = init_done_reg;
    overrun_next   = overrun_reg;

    if (accept) begin
      we_next    = 1'b1;
      waddr_next = ADDR_W'(word_reg);
      wdata_next = s_data_i;
      sel_next   = (state_reg == INIT_FILL) ? frame_reg : rptr_reg;
    end

    if (stop_i) begin
      state_next = IDLE;
      mu_next    = 1'b1;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start_i) begin
            ppl_next     = points_per_line_i;
            nof_next     = SEL_W'(nof_clamped);
            frame_next   = '0;
            word_next    = '0;
            rptr_next    = '0;
            overrun_next = 1'b0;
            if (points_per_line_i == 10'd0) begin
              state_next     = ARMED;
              init_done_next = 1'b1;
            end else begin
              state_next     = INIT_FILL;
              init_done_next = 1'b0;
            end
          end
        end
        INIT_FILL: begin
          if (accept) begin
            if (last_word) begin
              word_next = '0;
              if (frame_reg == nof_reg - SEL_W'(1)) begin
                frame_next = '0;
                rptr_next  = '0;
                state_next = ARMED;
              end else begin
                frame_next = frame_reg + SEL_W'(1);
              end
            end else begin
              word_next = word_reg + 10'd1;
            end
          end
        end
        ARMED: begin
          // init_done follows one cycle after the final initial write
          init_done_next = 1'b1;
          if (upd_edge) begin
            mu_next    = 1'b0;
            word_next  = '0;
            state_next = REFILL;
          end
        end
        REFILL: begin
          if (upd_edge) begin
            overrun_next = 1'b1;
          end
          if (ppl_reg == 10'd0) begin
            mu_next    = 1'b1;
            rptr_next  = rptr_adv;
            state_next = ARMED;
          end else if (accept) begin
            if (last_word) begin
              word_next  = '0;
              mu_next    = 1'b1;
              rptr_next  = rptr_adv;
              state_next = ARMED;
            end else begin
              word_next = word_reg + 10'd1;
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_r or negedge nrst_r) begin
    if (!nrst_r) begin
      state_reg     <= IDLE;
      ppl_reg       <= '0;
      word_reg      <= '0;
      nof_reg       <= '0;
      frame_reg     <= '0;
      rptr_reg      <= '0;
      waddr_reg     <= '0;
      wdata_reg     <= '0;
      we_reg        <= 1'b0;
      sel_reg       <= '0;
      mu_reg        <= 1'b1;
      init_done_reg <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      ppl_reg       <= ppl_next;
      word_reg      <= word_next;
      nof_reg       <= nof_next;
      frame_reg     <= frame_next;
      rptr_reg      <= rptr_next;
      waddr_reg     <= waddr_next;
      wdata_reg     <= wdata_next;
      we_reg        <= we_next;
      sel_reg       <= sel_next;
      mu_reg        <= mu_next;
      init_done_reg <= init_done_next;
      overrun_reg   <= overrun_next;
    end
  end

  assign waddr_o           = waddr_reg;
  assign wdata_o           = wdata_reg;
  assign we_o              = we_reg;
  assign memory_selector_o = sel_reg;
  assign mem_updated_o     = mu_reg;
  assign init_done_o       = init_done_reg;
  assign busy_o            = filling;
  assign overrun_o         = overrun_reg;

`ifdef TC_LOADER_STALL_CNT_EN
  logic [15:0] stall_reg;

  always_ff @(posedge clk_r or negedge nrst_r) begin
    if (!nrst_r) begin
      stall_reg <= '0;
    end else if (start_ok) begin
      stall_reg <= '0;
    end else if (filling && s_ready_o && !s_valid_i && (stall_reg != 16'hFFFF)) begin
      stall_reg <= stall_reg + 16'd1;
    end
  end

  assign stall_cnt_o = stall_reg;
`else
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_tc_line_mem_loader.sv
// Scoreboard bench for tc_line_mem_loader: expected writes queued when beats are accepted, compared on we_o.
module tb_tc_line_mem_loader;

  logic        clk_r = 1'b0;
  logic        nrst_r = 1'b0;
  logic        start_i = 1'b0;
  logic        stop_i = 1'b0;
  logic [9:0]  points_per_line_i = '0;
  logic [2:0]  number_of_frames_i = '0;
  logic [16:0] s_data_i = '0;
  logic        s_valid_i = 1'b0;
  logic        s_ready_o;
  logic        update_mem_i = 1'b0;
  logic [10:0] waddr_o;
  logic [16:0] wdata_o;
  logic        we_o;
  logic [2:0]  memory_selector_o;
  logic        mem_updated_o;
  logic        init_done_o;
  logic        busy_o;
  logic        overrun_o;
  logic [15:0] stall_cnt_o;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  tc_line_mem_loader #(.ADDR_W(11), .DATA_W(17), .SEL_W(3)) dut (
    .clk_r(clk_r), .nrst_r(nrst_r), .start_i(start_i), .stop_i(stop_i),
    .points_per_line_i(points_per_line_i), .number_of_frames_i(number_of_frames_i),
    .s_data_i(s_data_i), .s_valid_i(s_valid_i), .s_ready_o(s_ready_o),
    .update_mem_i(update_mem_i), .waddr_o(waddr_o), .wdata_o(wdata_o), .we_o(we_o),
    .memory_selector_o(memory_selector_o), .mem_updated_o(mem_updated_o),
    .init_done_o(init_done_o), .busy_o(busy_o), .overrun_o(overrun_o),
    .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk_r = ~clk_r;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // write monitor: every we_o must match the oldest expected {sel, addr, data}
  always @(negedge clk_r) begin
    if (nrst_r && we_o) begin
      if (exp_q.size() == 0) begin
        chk("wr_unexpected", 32'({memory_selector_o, waddr_o, wdata_o}), 32'hFFFF_FFFF);
      end else begin
        chk("wr", 32'({memory_selector_o, waddr_o, wdata_o}), exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk_r);
    #1;
  endtask

  task automatic do_start(input int ppl, input int nof);
    points_per_line_i  = 10'(ppl);
    number_of_frames_i = 3'(nof);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    $display("start ppl=%0d nof=%0d", ppl, nof);
  endtask

  task automatic do_stop();
    stop_i = 1'b1;
    tick();
    stop_i = 1'b0;
    $display("stop");
  endtask

  // Feeds beats frame by frame; expected target is derived from the bench's own frame/word counters.
  task automatic run_fill(input int nframes, input int first_sel, input int nof, input int ppl,
                          input int max_words, input bit half, input int inject_at);
    int words;
    int guard;
    logic [16:0] d;
    words = 0;
    for (int f = 0; f < nframes; f++) begin
      for (int w = 0; w < ppl; w++) begin
        if (words == max_words) begin
          s_valid_i = 1'b0;
          return;
        end
        if (half) begin
          s_valid_i = 1'b0;
          tick();
        end
        d = 17'($urandom);
        s_data_i  = d;
        s_valid_i = 1'b1;
        guard = 0;
        forever begin
          @(negedge clk_r);
          if (s_ready_o) break;
          guard++;
          if (guard > 200) begin
            chk("ready_timeout", 32'(guard), 32'd0);
            s_valid_i = 1'b0;
            return;
          end
        end
        exp_q.push_back(32'({3'((first_sel + f) % nof), 11'(w), d}));
        tick();
        words++;
        if (words == inject_at) update_mem_i = ~update_mem_i;
      end
      $display("frame sel=%0d ppl=%0d queued", (first_sel + f) % nof, ppl);
    end
    s_valid_i = 1'b0;
  endtask

  task automatic consume(input int sel, input int nof, input int ppl, input int inject_at,
                         input bit exp_ovr);
    update_mem_i = ~update_mem_i;
    tick();
    chk("mu_hold1", 32'(mem_updated_o), 32'd1);
    tick();
    chk("mu_hold2", 32'(mem_updated_o), 32'd1);
    tick();
    chk("mu_fall", 32'(mem_updated_o), 32'd0);
    chk("busy_refill", 32'(busy_o), 32'd1);
    run_fill(1, sel, nof, ppl, 100000, 1'b0, inject_at);
    chk("mu_rise", 32'(mem_updated_o), 32'd1);
    chk("overrun", 32'(overrun_o), 32'(exp_ovr));
    $display("consume sel=%0d done ovr=%0d", sel, overrun_o);
  endtask

  initial begin
    repeat (3) @(posedge clk_r);
    #1;
    chk("rst_we", 32'(we_o), 32'd0);
    chk("rst_ready", 32'(s_ready_o), 32'd0);
    chk("rst_mu", 32'(mem_updated_o), 32'd1);
    chk("rst_init_done", 32'(init_done_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_overrun", 32'(overrun_o), 32'd0);
    chk("rst_stall", 32'(stall_cnt_o), 32'd0);
    chk("rst_waddr", 32'(waddr_o), 32'd0);
    nrst_r = 1'b1;
    tick();

    // toggles before ARMED must be ignored
    update_mem_i = 1'b1;
    repeat (4) tick();
    chk("idle_edge_ignored", 32'(busy_o), 32'd0);

    // full initial fill 5 x 360
    do_start(360, 5);
    run_fill(5, 0, 5, 360, 100000, 1'b0, -1);
    chk("init_done_with_last_we", 32'(init_done_o), 32'd0);
    tick();
    chk("init_done_rise", 32'(init_done_o), 32'd1);
    chk("armed_not_busy", 32'(busy_o), 32'd0);
    tick();
    consume(0, 5, 360, -1, 1'b0);
    tick();
    consume(1, 5, 360, -1, 1'b0);

    do_stop();
    chk("stop_keeps_init_done", 32'(init_done_o), 32'd1);

    // nof=2 refill rotation, then overrun
    do_start(16, 2);
    run_fill(2, 0, 2, 16, 100000, 1'b0, -1);
    tick();
    consume(0, 2, 16, -1, 1'b0);
    consume(1, 2, 16, -1, 1'b0);
    consume(0, 2, 16, -1, 1'b0);
    consume(1, 2, 16, -1, 1'b0);
    consume(0, 2, 16, 10, 1'b1);
    repeat (6) tick();
    chk("no_requeue_busy", 32'(busy_o), 32'd0);
    chk("no_requeue_mu", 32'(mem_updated_o), 32'd1);
    consume(1, 2, 16, -1, 1'b1);

    // 50% valid duty: one stall cycle per word
    do_stop();
    do_start(8, 1);
    run_fill(1, 0, 1, 8, 100000, 1'b1, -1);
`ifdef TC_LOADER_STALL_CNT_EN
    chk("stall_cnt", 32'(stall_cnt_o), 32'd8);
`else
    chk("stall_cnt", 32'(stall_cnt_o), 32'd0);
`endif
    tick();
    chk("ppl8_init_done", 32'(init_done_o), 32'd1);

    // abort mid initial fill after address 100
    do_stop();
    do_start(360, 5);
    run_fill(5, 0, 5, 360, 101, 1'b0, -1);
    chk("pre_stop_we", 32'(we_o), 32'd1);
    do_stop();
    chk("stop_we", 32'(we_o), 32'd0);
    chk("stop_ready", 32'(s_ready_o), 32'd0);
    chk("stop_busy", 32'(busy_o), 32'd0);
    chk("stop_mu", 32'(mem_updated_o), 32'd1);
    chk("stop_init_done", 32'(init_done_o), 32'd0);

    // ppl=0: armed immediately, no writes
    do_start(0, 3);
    chk("ppl0_init_done", 32'(init_done_o), 32'd1);
    chk("ppl0_busy", 32'(busy_o), 32'd0);
    repeat (5) tick();
    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
